// File: rtl/alu_control.sv
// ALU control unit: decodes the funct field into per-unit operation codes and
// sequences the 32-cycle unsigned multiply, holding off new instructions meanwhile.
module alu_control #(
  parameter logic [5:0] AND   = 6'd36,
  parameter logic [5:0] OR    = 6'd37,
  parameter logic [5:0] ADD   = 6'd32,
  parameter logic [5:0] SUB   = 6'd34,
  parameter logic [5:0] SLT   = 6'd42,
  parameter logic [5:0] SRL   = 6'd2,
  parameter logic [5:0] MULTU = 6'd25,
  parameter logic [5:0] MFHI  = 6'd16,
  parameter logic [5:0] MFLO  = 6'd18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Signal,
  output logic [5:0] SignaltoALU,
  output logic [5:0] SignaltoSHT,
  output logic [5:0] SignaltoMUL,
  output logic [5:0] SignaltoMUX,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, MULT, FIN} state_t;

  state_t     state, nextState;
  logic [4:0] count, nextCount;
  logic [5:0] nextAlu, nextSht, nextMul, nextMux;
  logic       nextBusy, nextDone;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= 5'd0;
      SignaltoALU <= 6'd0;
      SignaltoSHT <= 6'd0;
      SignaltoMUL <= 6'd0;
      SignaltoMUX <= 6'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nextState;
      count       <= nextCount;
      SignaltoALU <= nextAlu;
      SignaltoSHT <= nextSht;
      SignaltoMUL <= nextMul;
      SignaltoMUX <= nextMux;
      busy        <= nextBusy;
      done        <= nextDone;
    end
  end

  // Signal is only looked at in IDLE; anything arriving during a multiply is dropped.
  always_comb begin
    nextState = state;
    nextCount = count;
    nextAlu   = 6'd0;
    nextSht   = 6'd0;
    nextMul   = 6'd0;
    nextMux   = 6'd0;
    nextBusy  = 1'b0;
    nextDone  = 1'b0;
    case (state)
      IDLE: begin
        case (Signal)
          AND, OR, ADD, SUB, SLT: begin
            nextAlu = Signal;
            nextMux = Signal;
          end
          SRL: begin
            nextSht = SRL;
            nextMux = SRL;
          end
          MFHI, MFLO: nextMux = Signal;
          MULTU: begin
            nextState = MULT;
            nextCount = 5'd0;
            nextMul   = MULTU;
            nextBusy  = 1'b1;
          end
          default: ;
        endcase
      end
      MULT: begin
        nextCount = count + 5'd1;
        nextBusy  = 1'b1;
        if (count == 5'd31) begin
          nextState = FIN;
          nextDone  = 1'b1;
        end else begin
          nextMul = MULTU;
        end
      end
      FIN: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_control.sv
// Directed-vector bench for alu_control; outputs are packed as
// {ALU, SHT, MUL, MUX, busy, done} and compared against hand-derived values.
module tb_alu_control;

  logic       clk;
  logic       reset;
  logic [5:0] Signal;
  logic [5:0] SignaltoALU, SignaltoSHT, SignaltoMUL, SignaltoMUX;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  alu_control dut (
    .clk(clk),
    .reset(reset),
    .Signal(Signal),
    .SignaltoALU(SignaltoALU),
    .SignaltoSHT(SignaltoSHT),
    .SignaltoMUL(SignaltoMUL),
    .SignaltoMUX(SignaltoMUX),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [25:0] pack(input logic [5:0] a, input logic [5:0] s,
                                       input logic [5:0] m, input logic [5:0] x,
                                       input logic b, input logic d);
    return {a, s, m, x, b, d};
  endfunction

  function automatic logic [25:0] observed();
    return {SignaltoALU, SignaltoSHT, SignaltoMUL, SignaltoMUX, busy, done};
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [25:0] exp;
    reset = 1'b1;
    Signal = 6'd32;
    step();
    step();
    exp = pack(0, 0, 0, 0, 0, 0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL reset_state got %h want %h", observed(), exp);
    end
    reset = 1'b0;
    step();
    exp = pack(32, 0, 0, 32, 0, 0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL first_add got %h want %h", observed(), exp);
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  ops [4] = '{6'd36, 6'd37, 6'd34, 6'd42};
    logic [25:0] exp;
    for (int i = 0; i < 4; i++) begin
      Signal = ops[i];
      step();
      exp = pack(ops[i], 0, 0, ops[i], 0, 0);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("[TB] FAIL alu_op_%0d got %h want %h", ops[i], observed(), exp);
      end
    end
  endtask

  task automatic test_srl_slt();
    logic [25:0] exp;
    Signal = 6'd2;
    step();
    exp = pack(0, 2, 0, 2, 0, 0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL srl got %h want %h", observed(), exp);
    end
    Signal = 6'd42;
    step();
    exp = pack(42, 0, 0, 42, 0, 0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL slt_after_srl got %h want %h", observed(), exp);
    end
  endtask

  task automatic test_move_and_nop();
    logic [5:0]  sigs [4] = '{6'd16, 6'd18, 6'd63, 6'd0};
    logic [5:0]  muxs [4] = '{6'd16, 6'd18, 6'd0, 6'd0};
    logic [25:0] exp;
    for (int i = 0; i < 4; i++) begin
      Signal = sigs[i];
      step();
      exp = pack(0, 0, 0, muxs[i], 0, 0);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("[TB] FAIL move_nop_%0d got %h want %h", sigs[i], observed(), exp);
      end
    end
  endtask

  // MULTU for one cycle, then AND held: the AND must be dropped until IDLE returns.
  task automatic test_multu();
    logic [25:0] exp;
    Signal = 6'd25;
    for (int c = 1; c <= 35; c++) begin
      step();
      if (c == 1) Signal = 6'd36;
      if (c <= 32)      exp = pack(0, 0, 25, 0, 1, 0);
      else if (c == 33) exp = pack(0, 0, 0, 0, 1, 1);
      else if (c == 34) exp = pack(0, 0, 0, 0, 0, 0);
      else              exp = pack(36, 0, 0, 36, 0, 0);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("[TB] FAIL multu_cycle_%0d got %h want %h", c, observed(), exp);
      end
    end
  endtask

  task automatic test_mult_reset();
    logic [25:0] exp;
    Signal = 6'd25;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) Signal = 6'd0;
    end
    exp = pack(0, 0, 25, 0, 1, 0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL mult_before_reset got %h want %h", observed(), exp);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp = pack(0, 0, 0, 0, 0, 0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL mult_abort got %h want %h", observed(), exp);
    end
    Signal = 6'd16;
    step();
    exp = pack(0, 0, 0, 16, 0, 0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("[TB] FAIL mfhi_after_abort got %h want %h", observed(), exp);
    end
    Signal = 6'd0;
    for (int c = 0; c < 30; c++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_no_done got busy=%b done=%b want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] exp;
    Signal = 6'd25;
    for (int c = 1; c <= 68; c++) begin
      step();
      if ((c >= 1 && c <= 32) || (c >= 35 && c <= 66)) exp = pack(0, 0, 25, 0, 1, 0);
      else if (c == 33 || c == 67)                     exp = pack(0, 0, 0, 0, 1, 1);
      else                                             exp = pack(0, 0, 0, 0, 0, 0);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("[TB] FAIL b2b_cycle_%0d got %h want %h", c, observed(), exp);
      end
      if (c == 66) Signal = 6'd0;
    end
  endtask

  initial begin
    reset = 1'b1;
    Signal = 6'd0;
    test_reset();
    test_alu_ops();
    test_srl_slt();
    test_move_and_nop();
    test_multu();
    test_mult_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
